// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand stage feeding the RV32I ALU (optional forwarding: EX_FORWARD_EN)
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_ALUSrcA,
    input  logic              id_ALUSrcB,
    input  logic [2:0]        id_ALUControl,
    input  logic              id_RegWrite,
    input  logic              flush,
    input  logic              mem_RegWrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_RegWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_result,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   srcA,
    output logic [XLEN-1:0]   srcB,
    output logic [2:0]        ALUControl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_RegWrite
);

    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rd1_q, rd1_d;
    logic [XLEN-1:0]   rd2_q, rd2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              alu_src_a_q, alu_src_a_d;
    logic              alu_src_b_q, alu_src_b_d;
    logic [2:0]        alu_control_q, alu_control_d;
    logic              reg_write_q, reg_write_d;

    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;
    logic              load;
    logic              stall;

    assign id_ready = !flush && (!ex_valid_q || ex_ready);
    assign load     = id_valid && id_ready;
    assign stall    = ex_valid_q && !ex_ready;

`ifdef EX_FORWARD_EN
    // Bypass MEM then WB results onto the held source registers; x0 is never bypassed
    always_comb begin
        fwd_a = rd1_q;
        if (mem_RegWrite && (mem_rd != '0) && (mem_rd == rs1_q))
            fwd_a = mem_result;
        else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs1_q))
            fwd_a = wb_result;
        fwd_b = rd2_q;
        if (mem_RegWrite && (mem_rd != '0) && (mem_rd == rs2_q))
            fwd_b = mem_result;
        else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs2_q))
            fwd_b = wb_result;
    end
`else
    // Hazards are resolved upstream, so the MEM/WB bypass ports are ignored
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_RegWrite, mem_rd, mem_result, wb_RegWrite, wb_rd, wb_result};
    assign fwd_a = rd1_q;
    assign fwd_b = rd2_q;
`endif

    // Next-state: flush beats load, load beats drain; stalled entries refresh their sources
    always_comb begin
        ex_valid_d    = ex_valid_q;
        pc_d          = pc_q;
        rd1_d         = rd1_q;
        rd2_d         = rd2_q;
        imm_d         = imm_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        alu_src_a_d   = alu_src_a_q;
        alu_src_b_d   = alu_src_b_q;
        alu_control_d = alu_control_q;
        reg_write_d   = reg_write_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (load) begin
            ex_valid_d    = 1'b1;
            pc_d          = id_pc;
            rd1_d         = id_rd1;
            rd2_d         = id_rd2;
            imm_d         = id_imm;
            rs1_d         = id_rs1;
            rs2_d         = id_rs2;
            rd_d          = id_rd;
            alu_src_a_d   = id_ALUSrcA;
            alu_src_b_d   = id_ALUSrcB;
            alu_control_d = id_ALUControl;
            reg_write_d   = id_RegWrite;
        end else if (stall) begin
            rd1_d = fwd_a;
            rd2_d = fwd_b;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Pipeline register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            pc_q          <= '0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            alu_src_a_q   <= 1'b0;
            alu_src_b_q   <= 1'b0;
            alu_control_q <= 3'd0;
            reg_write_q   <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            pc_q          <= pc_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_q         <= imm_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            alu_src_a_q   <= alu_src_a_d;
            alu_src_b_q   <= alu_src_b_d;
            alu_control_q <= alu_control_d;
            reg_write_q   <= reg_write_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign srcA          = alu_src_a_q ? pc_q : fwd_a;
    assign srcB          = alu_src_b_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ALUControl    = alu_control_q;
    assign ex_rd         = rd_q;
    assign ex_RegWrite   = ex_valid_q && reg_write_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_ALUSrcA, id_ALUSrcB;
    logic [2:0]  id_ALUControl;
    logic        id_RegWrite;
    logic        flush;
    logic        mem_RegWrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] srcA, srcB, ex_store_data;
    logic [2:0]  ALUControl;
    logic [4:0]  ex_rd;
    logic        ex_RegWrite;

    int checks = 0;
    int failures = 0;
    bit done = 0;

    typedef struct {
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        sa, sb, we;
        logic [2:0]  ctl;
    } entry_t;

    entry_t q[$];
    bit     zero_state = 1;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB),
        .id_ALUControl(id_ALUControl), .id_RegWrite(id_RegWrite),
        .flush(flush), .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd),
        .mem_result(mem_result), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
        .wb_result(wb_result), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value a source register should currently read, given the bypass buses
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
`ifdef EX_FORWARD_EN
        if (rs != 0 && mem_RegWrite && mem_rd == rs) return mem_result;
        if (rs != 0 && wb_RegWrite && wb_rd == rs) return wb_result;
`endif
        return rf;
    endfunction

    // Monitor: compare at negedge against the queued entry, then advance the model
    initial begin
        entry_t e;
        logic [31:0] fa, fb;
        bit exp_ready;
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            exp_ready = !flush && (q.size() == 0 || ex_ready);
            chk("id_ready", {31'd0, id_ready}, {31'd0, exp_ready});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                e  = q[0];
                fa = fwd(e.rs1, e.rd1);
                fb = fwd(e.rs2, e.rd2);
                chk("srcA", srcA, e.sa ? e.pc : fa);
                chk("srcB", srcB, e.sb ? e.imm : fb);
                chk("store_data", ex_store_data, fb);
                chk("ALUControl", {29'd0, ALUControl}, {29'd0, e.ctl});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                chk("ex_RegWrite", {31'd0, ex_RegWrite}, {31'd0, e.we});
            end else begin
                chk("ex_RegWrite_idle", {31'd0, ex_RegWrite}, 32'd0);
                if (zero_state) begin
                    chk("srcA_reset", srcA, 32'd0);
                    chk("srcB_reset", srcB, 32'd0);
                    chk("store_reset", ex_store_data, 32'd0);
                end
            end
            if (reset) begin
                q.delete();
                zero_state = 1;
            end else if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0) begin
                    if (ex_ready) begin
                        void'(q.pop_front());
                    end else begin
                        q[0].rd1 = fwd(q[0].rs1, q[0].rd1);
                        q[0].rd2 = fwd(q[0].rs2, q[0].rd2);
                    end
                end
                if (id_valid && exp_ready) begin
                    e.pc = id_pc; e.rd1 = id_rd1; e.rd2 = id_rd2; e.imm = id_imm;
                    e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd;
                    e.sa = id_ALUSrcA; e.sb = id_ALUSrcB; e.we = id_RegWrite;
                    e.ctl = id_ALUControl;
                    q.push_back(e);
                    zero_state = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] rs1, input logic [31:0] rd1, input logic [4:0] rs2,
                        input logic [31:0] rd2, input logic [31:0] imm, input logic sa,
                        input logic sb, input logic [2:0] ctl);
        id_valid = 1; id_rs1 = rs1; id_rd1 = rd1; id_rs2 = rs2; id_rd2 = rd2;
        id_imm = imm; id_ALUSrcA = sa; id_ALUSrcB = sb; id_ALUControl = ctl;
        id_pc = $urandom; id_rd = 5'($urandom); id_RegWrite = 1'($urandom);
    endtask

    initial begin
        reset = 1; id_valid = 1; id_pc = 32'h100; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ALUSrcA = 0; id_ALUSrcB = 0;
        id_ALUControl = 0; id_RegWrite = 1; flush = 0; mem_RegWrite = 0; mem_rd = 0;
        mem_result = 0; wb_RegWrite = 0; wb_rd = 0; wb_result = 0; ex_ready = 1;
        tick(); tick();
        reset = 0; id_valid = 0; tick();

        // Basic load
        beat(0, 5, 0, 0, 7, 0, 1, 3'b000); tick();
        id_valid = 0; tick();

        // Forwarding priority with the entry held
        ex_ready = 0;
        mem_RegWrite = 1; mem_rd = 3; mem_result = 32'hAA;
        wb_RegWrite = 1; wb_rd = 3; wb_result = 32'hBB;
        beat(3, 1, 0, 0, 0, 0, 0, 3'b001); tick();
        id_valid = 0; tick();
        mem_RegWrite = 0; tick();
        ex_ready = 1; tick();
        mem_RegWrite = 1; mem_rd = 0; wb_rd = 0;
        beat(0, 32'h55, 0, 0, 0, 0, 0, 3'b010); tick();
        id_valid = 0; tick();

        // Stall refresh: WB producer retires while stalled
        ex_ready = 0; mem_RegWrite = 0;
        wb_RegWrite = 1; wb_rd = 4; wb_result = 32'h1234;
        beat(0, 0, 4, 9, 0, 0, 0, 3'b011); tick();
        id_valid = 0; tick();
        wb_RegWrite = 0; tick(); tick(); tick();

        // Flush with a new beat offered
        flush = 1; beat(1, 2, 2, 3, 4, 0, 0, 3'b111); tick();
        flush = 0; id_valid = 0; ex_ready = 1; tick();

        // Back-to-back
        for (int i = 0; i < 4; i++) begin
            beat(0, i, 0, i, i, 0, 1, 3'(i)); tick();
        end
        id_valid = 0; tick(); tick();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            beat(5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                 $urandom, 1'($urandom), 1'($urandom), 3'($urandom));
            id_valid = 1'($urandom);
            mem_RegWrite = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_result = $urandom;
            wb_RegWrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_result = $urandom;
            tick();
        end
        reset = 0; flush = 0; id_valid = 0; ex_ready = 1;
        tick(); tick();
        done = 1;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the RV32I ALU.
- Registers decoded operands and control from decode, then applies MEM/WB forwarding and operand-source muxing.
- Drives srcA, srcB and ALUControl straight into the ALU.
- Uses a valid/ready handshake, supports flush (branch/jump redirect), and keeps forwarded operands coherent while stalled.

Parameters:
XLEN, 32, data/operand width
REG_AW, 5, register-address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
id_valid  input  1  decode offers an instruction
id_ready  output  1  stage can accept this cycle
id_pc  input  XLEN  PC of instruction
id_rd1  input  XLEN  regfile rs1 value
id_rd2  input  XLEN  regfile rs2 value
id_imm  input  XLEN  sign-extended immediate
id_rs1  input  REG_AW  rs1 address
id_rs2  input  REG_AW  rs2 address
id_rd  input  REG_AW  destination address
id_ALUSrcA  input  1  0=rs1, 1=PC
id_ALUSrcB  input  1  0=rs2, 1=imm
id_ALUControl  input  3  ALU op code
id_RegWrite  input  1  instruction writes rd
flush  input  1  kill the held entry
mem_RegWrite  input  1  MEM stage writes
mem_rd  input  REG_AW  MEM destination
mem_result  input  XLEN  MEM forward value
wb_RegWrite  input  1  WB stage writes
wb_rd  input  REG_AW  WB destination
wb_result  input  XLEN  WB forward value
ex_ready  input  1  downstream accepts the ALU result
ex_valid  output  1  entry valid, ALU inputs meaningful
srcA  output  XLEN  ALU operand A
srcB  output  XLEN  ALU operand B
ALUControl  output  3  ALU op, registered
ex_store_data  output  XLEN  forwarded rs2, for sw
ex_rd  output  REG_AW  registered rd
ex_RegWrite  output  1  registered RegWrite, gated by ex_valid

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: ex_valid=0. All registered fields (pc, rd1, rd2, imm, rs1, rs2, rd, ALUSrcA/B, ALUControl, RegWrite) = 0. srcA=srcB=0, ex_RegWrite=0.
- id_ready = !flush && (!ex_valid || ex_ready). Purely combinational; no dependence on id_valid.
- Load: when id_valid && id_ready, all id_* fields are captured at the clock edge; ex_valid<=1 next cycle. Latency is 1 cycle from accept to ALU inputs.
- Drain: when ex_valid && ex_ready && !(id_valid && id_ready), ex_valid<=0.
- Simultaneous drain and load: ex_valid stays 1 and the new entry replaces the old one; back-to-back throughput is 1 instruction per cycle.
- Stall: when ex_valid && !ex_ready, all fields hold, except that the rd1/rd2 registers are rewritten each cycle with their forwarded values (fwdA/fwdB). A producer that retires from WB during a stall is therefore not lost.
- Flush: has priority over load and hold. ex_valid<=0 next edge and no id beat is captured that cycle. Data registers may keep stale values, but ex_RegWrite=0.
- Forwarding, rs1 (combinational, from registered rs1):
  - mem_RegWrite && mem_rd!=0 && mem_rd==rs1 -> mem_result
  - else wb_RegWrite && wb_rd!=0 && wb_rd==rs1 -> wb_result
  - else registered rd1
  - MEM has priority over WB; x0 is never forwarded.
- Forwarding, rs2: identical rule, producing fwdB.
- Operand muxing:
  - srcA = ALUSrcA ? pc : fwdA
  - srcB = ALUSrcB ? imm : fwdB
  - ex_store_data = fwdB, regardless of ALUSrcB
- ex_RegWrite = ex_valid && RegWrite. ALUControl is passed through unchanged from its register.
- Reset mid-stall or mid-flush: reset wins; state returns to the reset values above.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding and stall-refresh behave as in Behaviour.
- Undefined: fwdA = registered rd1 and fwdB = registered rd2; no mem_*/wb_* comparison; rd1/rd2 simply hold during a stall. The mem_*/wb_* ports remain present but are ignored, and an external hazard unit must stall decode on RAW hazards.

Test Plan:
- Reset then idle: assert reset 2 cycles with id_valid=1 -> ex_valid=0, srcA=srcB=0, id_ready=1 after release.
- Basic load: id_rd1=5, id_imm=7, ALUSrcB=1, ALUControl=000, ex_ready=1 -> next cycle ex_valid=1, srcA=5, srcB=7, ALUControl=000.
- Forwarding priority:
  - Entry rs1=3, rd1=1; mem_rd=3, mem_result=0xAA; wb_rd=3, wb_result=0xBB, both RegWrite=1 -> srcA=0xAA.
  - Drop mem_RegWrite -> srcA=0xBB.
  - rs1=0 with mem_rd=0 -> srcA=rd1.
- Stall refresh: ex_ready=0, rs2=4, wb_rd=4, wb_result=0x1234 for 1 cycle, then wb_RegWrite=0 -> srcB and ex_store_data stay 0x1234 while stalled; id_ready=0.
- Flush: ex_valid=1, id_valid=1, flush=1 -> next cycle ex_valid=0, ex_RegWrite=0, new instruction not captured; id_ready=0 during flush.
- Back-to-back: 4 instructions with id_valid=1, ex_ready=1 -> 4 consecutive cycles ex_valid=1, in-order ALUControl 000,001,010,011.
